// File: rtl/huff_merge_sched.sv
// Huffman combine/split scheduler: runs NSYM-1 sort/merge rounds, stacks each merged pair,
// then replays the pairs in reverse order as split commands.
module huff_merge_sched #(
    parameter int unsigned NSYM    = 6,
    parameter int unsigned IDXW    = 3,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            sort_req,
    input  logic            sort_done,
    input  logic [IDXW-1:0] min0_idx,
    input  logic [IDXW-1:0] min1_idx,
    output logic            merge_en,
    output logic [IDXW-1:0] merge_a,
    output logic [IDXW-1:0] merge_b,
    output logic            split_en,
    output logic [IDXW-1:0] split_a,
    output logic [IDXW-1:0] split_b,
    output logic [IDXW-1:0] round,
    output logic            busy,
    output logic            done,
    output logic            err
);
    localparam int unsigned Depth = NSYM - 1;
    localparam int unsigned AW    = $clog2(Depth);
    localparam int unsigned SPW   = $clog2(NSYM);
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);
    localparam logic [IDXW-1:0] LastRound = IDXW'(NSYM - 2);

    typedef enum logic [2:0] {
        StIdle, StSortReq, StSortWait, StMerge, StSplit, StDone
    } state_e;

    state_e state_q, state_d;
    logic [IDXW-1:0] r_q, r_d;
    logic [SPW-1:0]  sp_q, sp_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [2*IDXW-1:0] stack_q [Depth];
    logic [2*IDXW-1:0] stack_d [Depth];

    logic sort_req_q, sort_req_d, merge_en_q, merge_en_d, split_en_q, split_en_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [IDXW-1:0] merge_a_q, merge_a_d, merge_b_q, merge_b_d;
    logic [IDXW-1:0] split_a_q, split_a_d, split_b_q, split_b_d, round_q, round_d;

    // Outputs are registered from the next state so each strobe lines up with its state.
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        sp_d       = sp_q;
        tcnt_d     = tcnt_q;
        stack_d    = stack_q;
        sort_req_d = 1'b0;
        merge_en_d = 1'b0;
        split_en_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        merge_a_d  = merge_a_q;
        merge_b_d  = merge_b_q;
        split_a_d  = split_a_q;
        split_b_d  = split_b_q;
        round_d    = round_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StSortReq;
                    r_d        = '0;
                    sp_d       = '0;
                    sort_req_d = 1'b1;
                end
            end
            StSortReq: begin
                tcnt_d  = '0;
                state_d = StSortWait;
            end
            StSortWait: begin
                if (sort_done) begin
                    if (min0_idx != min1_idx) begin
                        state_d    = StMerge;
                        merge_en_d = 1'b1;
                        merge_a_d  = min0_idx;
                        merge_b_d  = min1_idx;
                        round_d    = r_q;
                    end else begin
                        state_d = StIdle;
                        err_d   = 1'b1;
                    end
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            StMerge: begin
                stack_d[AW'(sp_q)] = {merge_a_q, merge_b_q};
                sp_d = sp_q + SPW'(1);
                if (r_q < LastRound) begin
                    r_d        = r_q + IDXW'(1);
                    state_d    = StSortReq;
                    sort_req_d = 1'b1;
                end else begin
                    // Top entry is being written this cycle, so forward it directly.
                    state_d                = StSplit;
                    split_en_d             = 1'b1;
                    {split_a_d, split_b_d} = {merge_a_q, merge_b_q};
                    round_d                = r_q;
                end
            end
            StSplit: begin
                sp_d = sp_q - SPW'(1);
                if (r_q == '0) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    r_d                    = r_q - IDXW'(1);
                    split_en_d             = 1'b1;
                    {split_a_d, split_b_d} = stack_q[AW'(sp_q - SPW'(2))];
                    round_d                = r_q - IDXW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            r_q        <= '0;
            sp_q       <= '0;
            tcnt_q     <= '0;
            for (int i = 0; i < int'(Depth); i++) stack_q[i] <= '0;
            sort_req_q <= 1'b0;
            merge_en_q <= 1'b0;
            split_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            merge_a_q  <= '0;
            merge_b_q  <= '0;
            split_a_q  <= '0;
            split_b_q  <= '0;
            round_q    <= '0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            sp_q       <= sp_d;
            tcnt_q     <= tcnt_d;
            stack_q    <= stack_d;
            sort_req_q <= sort_req_d;
            merge_en_q <= merge_en_d;
            split_en_q <= split_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            merge_a_q  <= merge_a_d;
            merge_b_q  <= merge_b_d;
            split_a_q  <= split_a_d;
            split_b_q  <= split_b_d;
            round_q    <= round_d;
        end
    end

    assign sort_req = sort_req_q;
    assign merge_en = merge_en_q;
    assign merge_a  = merge_a_q;
    assign merge_b  = merge_b_q;
    assign split_en = split_en_q;
    assign split_a  = split_a_q;
    assign split_b  = split_b_q;
    assign round    = round_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
endmodule
